// File: rtl/jstk_spi_reader_if.sv
// Signal bundle between the PmodJSTK poller (master side) and the joystick/consumer side (slave side).
interface jstk_spi_reader_if;
   logic       enable;
   logic [1:0] leds;
   logic       miso;
   logic       sclk;
   logic       mosi;
   logic       ss_n;
   logic [9:0] x_val;
   logic [9:0] y_val;
   logic [2:0] btn;
   logic       data_valid;
   logic       busy;

   modport master (
      input  enable, leds, miso,
      output sclk, mosi, ss_n, x_val, y_val, btn, data_valid, busy
   );

   modport slave (
      output enable, leds, miso,
      input  sclk, mosi, ss_n, x_val, y_val, btn, data_valid, busy
   );
endinterface

// File: rtl/jstk_spi_reader.sv
// Polls a PmodJSTK over a 5-byte mode-0 SPI transaction every POLL_PERIOD cycles.
// X/Y/buttons update atomically with a one-cycle data_valid pulse; no backpressure.
module jstk_spi_reader #(
   parameter int         HALF_PER    = 50,
   parameter int         SS_SETUP    = 1500,
   parameter int         BYTE_GAP    = 1000,
   parameter int         POLL_PERIOD = 1_000_000,
   parameter logic [9:0] RST_POS     = 10'd512
) (
   input  logic                  clk,
   input  logic                  rst,
   jstk_spi_reader_if.master     bus
);

   localparam int CNT_MAX = (SS_SETUP > BYTE_GAP)
                          ? ((SS_SETUP > 2*HALF_PER) ? SS_SETUP : 2*HALF_PER)
                          : ((BYTE_GAP > 2*HALF_PER) ? BYTE_GAP : 2*HALF_PER);
   localparam int CNT_W  = $clog2(CNT_MAX + 1);
   localparam int POLL_W = $clog2(POLL_PERIOD + 1);

   localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SS_SETUP - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(BYTE_GAP - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_PER - 1);
   localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(2*HALF_PER - 1);
   localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        r_state;
   logic [POLL_W-1:0] r_poll;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_bit;
   logic [2:0]        r_byte;
   logic [7:0]        r_tx;
   logic [7:0]        r_sh;
   logic [7:0]        r_b0;
   logic [1:0]        r_b1;
   logic [7:0]        r_b2;
   logic [1:0]        r_b3;
   logic              r_sclk;
   logic              r_ss_n;
   logic              r_busy;
   logic              r_dv;
   logic [9:0]        r_x;
   logic [9:0]        r_y;
   logic [2:0]        r_btn;
   logic              w_tick;

   assign w_tick = (r_poll == POLL_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_poll  <= '0;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_byte  <= '0;
         r_tx    <= '0;
         r_sh    <= '0;
         r_b0    <= '0;
         r_b1    <= '0;
         r_b2    <= '0;
         r_b3    <= '0;
         r_sclk  <= 1'b0;
         r_ss_n  <= 1'b1;
         r_busy  <= 1'b0;
         r_dv    <= 1'b0;
         r_x     <= RST_POS;
         r_y     <= RST_POS;
         r_btn   <= '0;
      end else begin
         r_poll <= w_tick ? '0 : r_poll + 1'b1;
         r_dv   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_tick && bus.enable) begin
                  r_state <= S_SETUP;
                  r_ss_n  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_byte  <= '0;
                  r_bit   <= '0;
                  r_cnt   <= '0;
                  // mosi is r_tx[7], so bit7 of byte0 is on the wire through SETUP
                  r_tx    <= {6'b100000, bus.leds};
               end
            end
            S_SETUP: begin
               if (r_cnt == SETUP_LAST) begin
                  r_state <= S_SHIFT;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_SHIFT: begin
               if (r_cnt == HALF_LAST) begin
                  r_sclk <= 1'b1;
                  r_sh   <= {r_sh[6:0], bus.miso};
                  r_cnt  <= r_cnt + 1'b1;
               end else if (r_cnt == BIT_LAST) begin
                  r_sclk <= 1'b0;
                  r_cnt  <= '0;
                  r_tx   <= {r_tx[6:0], 1'b0};
                  if (r_bit == 3'd7) begin
                     r_bit <= '0;
                     case (r_byte)
                        3'd0:    r_b0 <= r_sh;
                        3'd1:    r_b1 <= r_sh[1:0];
                        3'd2:    r_b2 <= r_sh;
                        3'd3:    r_b3 <= r_sh[1:0];
                        default: ;
                     endcase
                     if (r_byte == 3'd4) begin
                        r_state <= S_DONE;
                        r_x     <= {r_b1, r_b0};
                        r_y     <= {r_b3, r_b2};
                        r_btn   <= r_sh[2:0];
                        r_dv    <= 1'b1;
                     end else begin
                        r_state <= S_GAP;
                        r_byte  <= r_byte + 1'b1;
                     end
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_state <= S_SHIFT;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ss_n  <= 1'b1;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.sclk       = r_sclk;
   assign bus.mosi       = r_tx[7];
   assign bus.ss_n       = r_ss_n;
   assign bus.x_val      = r_x;
   assign bus.y_val      = r_y;
   assign bus.btn        = r_btn;
   assign bus.data_valid = r_dv;
   assign bus.busy       = r_busy;

endmodule
